// File: rtl/fpu_issue_ctrl_if.sv
// Decode-to-FPU issue interface: decode operands in, stall/forward/tag tracking out.
interface fpu_issue_ctrl_if #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned AW     = 5,
  parameter int unsigned CW     = 5
);
  logic                 id_valid;
  logic [AW-1:0]        id_fs;
  logic [AW-1:0]        id_ft;
  logic                 id_use_fs;
  logic                 id_use_ft;
  logic [AW-1:0]        id_fd;
  logic                 id_wf;
  logic                 id_div;
  logic                 id_sqrt;
  logic                 ext_stall;
  logic                 stall;
  logic                 fwd_a;
  logic                 fwd_b;
  logic [STAGES*AW-1:0] e_n;
  logic [STAGES-1:0]    e_w;
  logic [AW-1:0]        wb_n;
  logic                 wb_w;
  logic                 busy;
  logic [CW-1:0]        count;

  modport master (
    output id_valid, id_fs, id_ft, id_use_fs, id_use_ft, id_fd, id_wf,
           id_div, id_sqrt, ext_stall,
    input  stall, fwd_a, fwd_b, e_n, e_w, wb_n, wb_w, busy, count
  );

  modport slave (
    input  id_valid, id_fs, id_ft, id_use_fs, id_use_ft, id_fd, id_wf,
           id_div, id_sqrt, ext_stall,
    output stall, fwd_a, fwd_b, e_n, e_w, wb_n, wb_w, busy, count
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// FPU issue/hazard controller: tracks destination tags through e1..eSTAGES and wb,
// stalls decode on RAW hazards or iterative div/sqrt, and selects last-stage forwarding.
module fpu_issue_ctrl #(
  parameter int unsigned STAGES      = 3,
  parameter int unsigned AW          = 5,
  parameter int unsigned DIV_CYCLES  = 16,
  parameter int unsigned SQRT_CYCLES = 16,
  parameter int unsigned CW          = 5
) (
  input  logic              clock,
  input  logic              resetn,
  fpu_issue_ctrl_if.slave   io
);

  logic [STAGES-1:0][AW-1:0] tag_q;
  logic [STAGES-1:0]         w_q;
  logic [AW-1:0]             wb_n_q;
  logic                      wb_w_q;
  logic                      busy_q;
  logic [CW-1:0]             count_q;

  logic [STAGES-1:0] hit_a, hit_b;
  logic              early_a, early_b, last_a, last_b;
  logic              raw_a, raw_b, stall_c, issue_c;

  // Per-stage tag match; any hit younger than the last stage is a hazard,
  // a hit only in the last stage is forwardable.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 0; k < STAGES; k++) begin
      hit_a[k] = w_q[k] && (tag_q[k] == io.id_fs);
      hit_b[k] = w_q[k] && (tag_q[k] == io.id_ft);
    end
  end

  assign early_a = |hit_a[STAGES-2:0];
  assign early_b = |hit_b[STAGES-2:0];
  assign last_a  = hit_a[STAGES-1] & ~early_a;
  assign last_b  = hit_b[STAGES-1] & ~early_b;

  assign raw_a   = io.id_valid & io.id_use_fs & early_a;
  assign raw_b   = io.id_valid & io.id_use_ft & early_b;
  assign stall_c = io.id_valid & (raw_a | raw_b | busy_q);
  assign issue_c = io.id_valid & ~stall_c & ~io.ext_stall;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tag_q   <= '0;
      w_q     <= '0;
      wb_n_q  <= '0;
      wb_w_q  <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      if (!busy_q) begin
        tag_q[0] <= issue_c ? io.id_fd : '0;
        w_q[0]   <= issue_c & io.id_wf;
        if (issue_c && io.id_div) begin
          count_q <= CW'(DIV_CYCLES - 1);
          busy_q  <= (DIV_CYCLES > 1);
        end else if (issue_c && io.id_sqrt) begin
          count_q <= CW'(SQRT_CYCLES - 1);
          busy_q  <= (SQRT_CYCLES > 1);
        end
      end else begin
        // e1 holds the iterating op; the stage behind it sees bubbles.
        count_q <= count_q - CW'(1);
        busy_q  <= (count_q > CW'(1));
      end
      tag_q[1] <= busy_q ? '0 : tag_q[0];
      w_q[1]   <= busy_q ? 1'b0 : w_q[0];
      for (int k = 2; k < STAGES; k++) begin
        tag_q[k] <= tag_q[k-1];
        w_q[k]   <= w_q[k-1];
      end
      wb_n_q <= tag_q[STAGES-1];
      wb_w_q <= w_q[STAGES-1];
    end
  end

  assign io.stall = stall_c;
  assign io.fwd_a = io.id_valid & io.id_use_fs & last_a;
  assign io.fwd_b = io.id_valid & io.id_use_ft & last_b;
  assign io.e_n   = tag_q;
  assign io.e_w   = w_q;
  assign io.wb_n  = wb_n_q;
  assign io.wb_w  = wb_w_q;
  assign io.busy  = busy_q;
  assign io.count = count_q;

endmodule
